// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the UART receive deframer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
//
// Contents: frame FSM state encoding, data bits per frame, and the
// mid-bit sample point helper used to place the majority-vote samples.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Centre of a bit period, in clock cycles from the start of the bit.
  function automatic int mid_of(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte stream handshake carrying received bytes to the consumer.
// Latency: n/a (wires only).
// Backpressure: consumer holds m_ready low to keep the head byte in place.
//
// Signals: m_data (byte at FIFO head), m_valid (byte available),
// m_ready (consumer takes m_data this cycle).
// Modports: master = deframer side, slave = consumer side.
interface uart_rx_deframer_if;
  import uart_rx_pkg::*;

  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
// Latency: a push is visible on pop_data/empty the edge it is written.
// Backpressure: push while full is refused unless a pop happens the same cycle.
//
// Ports: clk, rst_n (async active-low), push/push_data (write side),
// full, pop (ignored while empty), empty, pop_data (head entry, always driven).
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART 8N1 receiver: synchronizes rx, majority-votes each bit, buffers bytes.
// Latency: byte lands in the FIFO on the edge after the stop-bit decision.
// Backpressure: m_ready low fills the FIFO; a byte arriving when full is dropped (overflow).
//
// Ports: clk, rst_n (async active-low), rx (raw serial line, idle high),
// m_if (master handshake: m_data/m_valid out, m_ready in),
// is_receiving (FSM not idle), frame_err / overflow (one-cycle pulses).
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  uart_rx_deframer_if.master  m_if,
  output logic                is_receiving,
  output logic                frame_err,
  output logic                overflow
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = mid_of(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_S0    = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC   = CW'(MID + 1);
  localparam logic [CW-1:0] CNT_PHASE = CW'(MID + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;

  logic majority;
  logic decide;
  logic push;
  logic fifo_full;
  logic fifo_empty;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_q),
    .full      (fifo_full),
    .pop       (m_if.m_ready),
    .empty     (fifo_empty),
    .pop_data  (m_if.m_data)
  );

  assign m_if.m_valid = !fifo_empty;
  assign is_receiving = (state_q != ST_IDLE);
  assign frame_err    = frame_err_q;
  assign overflow     = overflow_q;

  // Two earlier samples are held; the third is the live rx_s at the decision point.
  assign majority = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
  assign decide   = (cnt_q == CNT_DEC);

  always_comb begin
    rx_meta_d   = rx;
    rx_s_d      = rx_meta_q;
    rx_prev_d   = rx_s_q;
    state_d     = state_q;
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    samp0_d     = (cnt_q == CNT_S0) ? rx_s_q : samp0_q;
    samp1_d     = (cnt_q == CNT_S1) ? rx_s_q : samp1_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (decide) begin
          if (majority) begin
            state_d = ST_IDLE;
          end else begin
            // Jump the counter forward so the next decision lands one full
            // bit period later, i.e. mid-way through data bit 0.
            state_d   = ST_DATA;
            cnt_d     = CNT_PHASE;
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = {majority, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (majority) begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
            cnt_d       = '0;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Require one full bit time of idle line so a break cannot retrigger.
        if (!rx_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    overflow_d = push && fifo_full && !m_if.m_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      cnt_q       <= '0;
      samp0_q     <= 1'b1;
      samp1_q     <= 1'b1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      cnt_q       <= cnt_d;
      samp0_q     <= samp0_d;
      samp1_q     <= samp1_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Standalone UART receive path: recovers 8N1 bytes from the asynchronous RS232_Rx line and buffers them in a small FIFO with a valid/ready output handshake.
- Receive-side counterpart to the board's transmit test path.
- Feeds downstream command/pulse-parameter logic.
- Fixed frame: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.

Parameters:
- CLKS_PER_BIT, 1250, clock cycles per bit (12 MHz / 9600 baud); must be ≥ 8.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial line; idle high; asynchronous to clk.
- m_data  out  8  byte at FIFO head.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- is_receiving  out  1  high when the frame FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  one-cycle pulse: completed byte dropped because FIFO full.

Behaviour:
- Reset values: m_valid 0, m_data 0, is_receiving 0, frame_err 0, overflow 0.
- Reset clears the FIFO, returns the FSM to IDLE, and forces both synchronizer flops to 1.
- Reset mid-frame discards the partial byte.
- Synchronizer: rx passes through 2 flops to give rx_s. All logic uses rx_s only.
- Sampling: bit counter (clog2(CLKS_PER_BIT) bits) is cleared on a state entry.
- Bit value is the majority of three rx_s samples at counter = MID-1, MID, MID+1, where MID = CLKS_PER_BIT/2.
- The decision is registered at MID+1.
- FSM states:
  - IDLE: on rx_s 1→0 (previous sample 1, current 0) go to START and clear the counter.
  - START: at the MID+1 decision, majority 1 = false start (glitch): return to IDLE, no flags. Majority 0: go to DATA and re-phase so subsequent decisions fall every CLKS_PER_BIT cycles.
  - DATA: shift the decision into bit index 0..7, LSB first. After bit 7 go to STOP.
  - STOP, majority 1: push the byte to the FIFO and go to IDLE immediately (mid stop bit), so a back-to-back start bit is caught.
  - STOP, majority 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s = 1 for one full CLKS_PER_BIT, then go to IDLE. This prevents break conditions re-triggering.
- Latency: byte written at the clock edge after the stop-bit decision. With the FIFO empty, m_valid rises that same edge.
- FIFO (first-word fall-through):
  - m_data is always the head entry.
  - Pop when m_valid && m_ready.
  - Count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- FIFO boundary cases:
  - Push when full without a same-cycle pop: byte dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only, since m_valid was 0.
  - m_ready while empty: ignored.
- frame_err and overflow are never asserted together. Each is high for exactly one cycle per event.

Decomposition:
- Package uart_rx_pkg holds:
  - state encoding enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - DATA_BITS = 8;
  - function for the MID computation.
- Sub-module uart_rx_fifo: generic synchronous FWFT FIFO parameterized by WIDTH and DEPTH, exposing push, full, pop, empty and data.
- Synchronizer, sampler and FSM stay in the top module.

Test Plan:
- CLKS_PER_BIT=16. Send 0x41 (line: 0, 1,0,0,0,0,0,1,0, 1) → m_valid rises one clock after the stop decision, m_data=0x41, no flags; pop with m_ready → m_valid 0.
- rx low for 3 clocks then high → is_receiving pulses; no byte, no frame_err; FSM back in IDLE before MID+2.
- Send 0x55 with stop bit 0, hold rx low 40 clocks, then high → one frame_err pulse, FIFO empty. A following 0x3C sent after 16+ idle clocks is received correctly.
- m_ready=0, send 0x01..0x05 back-to-back → FIFO holds 0x01..0x04, one overflow pulse on the 5th. Draining yields exactly 0x01,0x02,0x03,0x04.
- FIFO full, m_ready=1 held while a 6th byte 0xAA completes → simultaneous push/pop, no overflow. Drain order 0x01..0x04 then 0xAA.
- Assert rst_n low during bit 3 of 0xF0 → all outputs 0 asynchronously. After release, a fresh 0x0F is received as 0x0F with no error.
